// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between issue logic and the RV32M multiply/divide unit
//
// Signals:
//   start_pi     request strobe, sampled by the unit only while it is idle
//   funct3_pi    RV32M operation select
//   operand1_pi  rs1 value
//   operand2_pi  rs2 value
//   destReg_pi   rd index of the request
//   busy_po      unit is working on an accepted request
//   done_po      one-cycle completion pulse
//   result_po    completed result, held until the next completion
//   destReg_po   rd of the completed request
//   we_po        register file write enable
//
// Modports:
//   master  issue side (drives the request, observes the response)
//   slave   the multiply/divide unit

interface muldiv_unit_if;
    logic        start_pi;
    logic [2:0]  funct3_pi;
    logic [31:0] operand1_pi;
    logic [31:0] operand2_pi;
    logic [4:0]  destReg_pi;
    logic        busy_po;
    logic        done_po;
    logic [31:0] result_po;
    logic [4:0]  destReg_po;
    logic        we_po;

    modport master (
        output start_pi, funct3_pi, operand1_pi, operand2_pi, destReg_pi,
        input  busy_po, done_po, result_po, destReg_po, we_po
    );

    modport slave (
        input  start_pi, funct3_pi, operand1_pi, operand2_pi, destReg_pi,
        output busy_po, done_po, result_po, destReg_po, we_po
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one radix-2 step per cycle
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    muldiv_unit_if.slave request/response bundle
//
// Build option:
//   SWITCHMCU_DIV_EN  defined   -> all eight funct3 ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//                     undefined -> divider datapath omitted; divide ops complete with the same
//                                  timing, result 0 and no register write
//
// Timing: request accepted at edge N, 32 iterations on edges N+1..N+32, DONE for one cycle
// after edge N+32, idle again after edge N+33.

module muldiv_unit (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [4:0]  cnt_q;
    logic [2:0]  f3_q;
    logic        neg_q;       // final result must be negated
    logic [31:0] mag_q;       // multiplicand (multiply) or divisor (divide) magnitude
    logic [63:0] work_q;      // multiply: {partial product, multiplier}; divide: {remainder, quotient}
    logic [4:0]  rd_lat_q;    // rd of the request in flight
    logic [31:0] result_q;
    logic [4:0]  rd_q;

    // Accept-time operand conditioning
    logic        op1_signed;
    logic        op2_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        neg_init;

    // Iteration datapath
    logic [32:0] add_sum;
    logic [63:0] mul_step;
    logic [63:0] work_d;
    logic [63:0] mul_full;
    logic [31:0] mul_res;
    logic [31:0] final_res;

`ifdef SWITCHMCU_DIV_EN
    logic [32:0] shifted;
    logic        ge;
    logic [63:0] div_step;
    logic [31:0] div_val;
    logic [31:0] div_res;
`endif

    always_comb begin
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        case (bus.funct3_pi)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            3'b010:  op1_signed = 1'b1;
            default: ;
        endcase

        a_neg = op1_signed & bus.operand1_pi[31];
        b_neg = op2_signed & bus.operand2_pi[31];
        a_mag = a_neg ? (32'd0 - bus.operand1_pi) : bus.operand1_pi;
        b_mag = b_neg ? (32'd0 - bus.operand2_pi) : bus.operand2_pi;

        // Remainder follows the dividend; a zero divisor keeps the all-ones quotient unsigned.
        if (!bus.funct3_pi[2])
            neg_init = a_neg ^ b_neg;
        else if (bus.funct3_pi[1])
            neg_init = a_neg;
        else
            neg_init = (a_neg ^ b_neg) & (|bus.operand2_pi);
    end

    always_comb begin
        // Shift-add: conditionally add multiplicand to the high half, then shift the
        // 65-bit {carry, high, low} right by one; the multiplier drains out of the low half.
        add_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, mag_q} : 33'd0);
        mul_step = {add_sum, work_q[31:1]};

`ifdef SWITCHMCU_DIV_EN
        // Restoring divide: bring the next dividend bit into the remainder and subtract
        // when it fits. A zero divisor always "fits", giving all-ones quotient and
        // remainder equal to the dividend without special handling.
        shifted  = {work_q[63:32], work_q[31]};
        ge       = (shifted >= {1'b0, mag_q});
        div_step = ge ? {shifted[31:0] - mag_q, work_q[30:0], 1'b1}
                      : {shifted[31:0],         work_q[30:0], 1'b0};
        work_d   = f3_q[2] ? div_step : mul_step;
`else
        work_d   = mul_step;
`endif

        mul_full = neg_q ? (64'd0 - work_d) : work_d;
        mul_res  = (f3_q[1:0] == 2'b00) ? mul_full[31:0] : mul_full[63:32];

`ifdef SWITCHMCU_DIV_EN
        div_val   = f3_q[1] ? work_d[63:32] : work_d[31:0];
        div_res   = neg_q ? (32'd0 - div_val) : div_val;
        final_res = f3_q[2] ? div_res : mul_res;
`else
        final_res = f3_q[2] ? 32'd0 : mul_res;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_pi) state_d = RUN;
            RUN:     if (cnt_q == 5'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= 5'd0;
            f3_q     <= 3'd0;
            neg_q    <= 1'b0;
            mag_q    <= 32'd0;
            work_q   <= 64'd0;
            rd_lat_q <= 5'd0;
            result_q <= 32'd0;
            rd_q     <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_pi) begin
                        f3_q     <= bus.funct3_pi;
                        neg_q    <= neg_init;
                        rd_lat_q <= bus.destReg_pi;
                        cnt_q    <= 5'd31;
                        if (bus.funct3_pi[2]) begin
                            work_q <= {32'd0, a_mag};
                            mag_q  <= b_mag;
                        end else begin
                            work_q <= {32'd0, b_mag};
                            mag_q  <= a_mag;
                        end
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    if (cnt_q == 5'd0) begin
                        result_q <= final_res;
                        rd_q     <= rd_lat_q;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_po    = (state_q != IDLE);
    assign bus.done_po    = (state_q == DONE);
    assign bus.result_po  = result_q;
    assign bus.destReg_po = rd_q;
`ifdef SWITCHMCU_DIV_EN
    assign bus.we_po      = bus.done_po & (|rd_q);
`else
    assign bus.we_po      = bus.done_po & (|rd_q) & ~f3_q[2];
`endif

endmodule
